// File: rtl/alu_ctrl_muldiv.sv
// -----------------------------------------------------------------------------
// alu_ctrl_muldiv
// EX-stage ALU control with an iterative multiply/divide unit.
//
// Decodes alu_op/funct into the 4-bit ALU control code. It also runs
// MULT/MULTU (shift-add) and DIV/DIVU (restoring division) one bit per cycle
// into the HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. Any HI/LO-dependent
// instruction that meets a busy unit raises stall to hold IF..EX.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high
//   valid    in   1      EX-stage instruction valid
//   alu_op   in   4      4'b1111 selects funct decode, otherwise passed through
//   funct    in   6      R-type function field
//   src_a    in   WIDTH  rs: dividend / multiplicand / MTHI-MTLO source
//   src_b    in   WIDTH  rt: divisor / multiplier
//   alu_ctrl out  4      ALU control code (combinational)
//   stall    out  1      HI/LO-dependent op while the unit is busy
//   busy     out  1      multiply/divide unit iterating (registered)
//   hilo_rd  out  WIDTH  HI on MFHI, LO on MFLO, else 0
//   div0     out  1      one-cycle pulse in the FIX cycle of a divide by zero
//
// Build option:
//   MULDIV_EARLY_TERM_EN - a multiply leaves MUL as soon as the remaining
//   multiplier bits are all zero (busy 2..WIDTH+1 cycles). When undefined,
//   a multiply always takes WIDTH+1 busy cycles.
// -----------------------------------------------------------------------------
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       alu_ctrl,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_rd,
  output logic             div0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] op_a_q, op_a_d;   // multiplicand, shifted left each MUL cycle
  logic [WIDTH-1:0]   op_b_q, op_b_d;   // multiplier (shifted right) or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or {remainder, quotient} while dividing
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient in FIX
  logic               neg_rem_q, neg_rem_d;  // negate remainder in FIX
  logic               dz_q, dz_d;            // divide by zero in flight
  logic               busy_q, busy_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_r_s;
  logic               is_md_s;
  logic               is_arith_s;
  logic               is_divop_s;
  logic               is_signed_s;
  logic               dep_s;
  logic               start_s;
  logic               mthi_s;
  logic               mtlo_s;
  logic               sign_a_s;
  logic               sign_b_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic               mul_zero_s;

  assign is_r_s = (alu_op == 4'b1111);

  // ALU control decode; forced to NOP while reset is held
  always_comb begin
    alu_ctrl = 4'b0000;
    if (reset) begin
      alu_ctrl = 4'b0000;
    end else if (is_r_s) begin
      case (funct)
        6'b000000: alu_ctrl = 4'b1001;
        6'b000010: alu_ctrl = 4'b1110;
        6'b000011: alu_ctrl = 4'b1101;
        6'b100000: alu_ctrl = 4'b0111;
        6'b100001: alu_ctrl = 4'b0001;
        6'b100010: alu_ctrl = 4'b0010;
        6'b100011: alu_ctrl = 4'b0011;
        6'b100100: alu_ctrl = 4'b0100;
        6'b100101: alu_ctrl = 4'b0101;
        6'b100110: alu_ctrl = 4'b0110;
        6'b101010: alu_ctrl = 4'b1010;
        6'b101011: alu_ctrl = 4'b1011;
        default:   alu_ctrl = 4'b0000;
      endcase
    end else begin
      alu_ctrl = alu_op;
    end
  end

  // Classify the multiply/divide family of functs
  always_comb begin
    is_md_s     = 1'b0;
    is_arith_s  = 1'b0;
    is_divop_s  = 1'b0;
    is_signed_s = 1'b0;
    case (funct)
      F_MULT: begin
        is_md_s = 1'b1; is_arith_s = 1'b1; is_signed_s = 1'b1;
      end
      F_MULTU: begin
        is_md_s = 1'b1; is_arith_s = 1'b1;
      end
      F_DIV: begin
        is_md_s = 1'b1; is_arith_s = 1'b1; is_divop_s = 1'b1; is_signed_s = 1'b1;
      end
      F_DIVU: begin
        is_md_s = 1'b1; is_arith_s = 1'b1; is_divop_s = 1'b1;
      end
      F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin
        is_md_s = 1'b1;
      end
      default: begin
        is_md_s = 1'b0;
      end
    endcase
  end

  assign dep_s   = valid & is_r_s & is_md_s;
  assign stall   = dep_s & busy_q;
  assign start_s = dep_s & ~busy_q & is_arith_s;
  assign mthi_s  = dep_s & ~busy_q & (funct == F_MTHI);
  assign mtlo_s  = dep_s & ~busy_q & (funct == F_MTLO);

  // Signed ops iterate on magnitudes; the signs are fixed up in FIX
  assign sign_a_s = is_signed_s & src_a[WIDTH-1];
  assign sign_b_s = is_signed_s & src_b[WIDTH-1];
  assign abs_a_s  = sign_a_s ? -src_a : src_a;
  assign abs_b_s  = sign_b_s ? -src_b : src_b;

  // Restoring-division step: shift the next dividend bit into the remainder
  assign shifted_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, op_b_q};

  assign quo_fix_s  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix_s = neg_res_q ? -acc_q : acc_q;

`ifdef MULDIV_EARLY_TERM_EN
  assign mul_zero_s = (op_b_q == {WIDTH{1'b0}});
`else
  assign mul_zero_s = 1'b0;
`endif

  // Next-state logic for the sequencer, datapath and HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div0_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          is_div_d  = is_divop_s;
          neg_res_d = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          cnt_d     = {CNT_W{1'b0}};
          dz_d      = 1'b0;
          if (is_divop_s) begin
            if (src_b == {WIDTH{1'b0}}) begin
              // Zero divisor skips the iterations; keep the raw dividend for HI
              dz_d    = 1'b1;
              div0_d  = 1'b1;
              acc_d   = {{WIDTH{1'b0}}, src_a};
              state_d = S_FIX;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, abs_a_s};
              op_b_d  = abs_b_s;
              state_d = S_DIV;
            end
          end else begin
            op_a_d  = {{WIDTH{1'b0}}, abs_a_s};
            op_b_d  = abs_b_s;
            acc_d   = {2*WIDTH{1'b0}};
            state_d = S_MUL;
          end
        end else if (mthi_s) begin
          hi_d = src_a;
        end else if (mtlo_s) begin
          lo_d = src_a;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_zero_s) begin
          state_d = S_FIX;
        end else begin
          if (op_b_q[0]) begin
            acc_d = acc_q + op_a_q;
          end else begin
            acc_d = acc_q;
          end
          op_a_d = op_a_q << 1;
          op_b_d = op_b_q >> 1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_DIV: begin
        if (!diff_s[WIDTH]) begin
          acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {shifted_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = acc_q[WIDTH-1:0];
        end else if (is_div_q) begin
          lo_d = quo_fix_s;
          hi_d = rem_fix_s;
        end else begin
          lo_d = prod_fix_s[WIDTH-1:0];
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
        end
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      op_a_q    <= {2*WIDTH{1'b0}};
      op_b_q    <= {WIDTH{1'b0}};
      acc_q     <= {2*WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign div0 = div0_q;

  // Same-cycle HI/LO read port
  always_comb begin
    hilo_rd = {WIDTH{1'b0}};
    if (valid && is_r_s && (funct == F_MFHI)) begin
      hilo_rd = hi_q;
    end else if (valid && is_r_s && (funct == F_MFLO)) begin
      hilo_rd = lo_q;
    end else begin
      hilo_rd = {WIDTH{1'b0}};
    end
  end

endmodule
